fetch_stage: RTL and testbench

//   IF stage; produces the IF/ID pipeline register that the decode stage consumes (InstrDe, PCDe, PCplus4De).

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_buf.sv | 81 ++++++++
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: word width, NOP encoding and the IF/ID register layout.
package fetch_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t pc4;
        logic  valid;
    } ifid_t;

    function automatic word_t pc_plus4(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_buf.sv
// fetch_buf: in-order buffer of requested instructions; entries are allocated at request
// time and filled by responses in order, so the oldest unfilled entry is always the next to fill.
module fetch_buf
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_data_i,
    input  logic            pop_i,
    output logic            head_valid_o,
    output logic            head_filled_o,
    output logic [XLEN-1:0] head_pc_o,
    output logic [XLEN-1:0] head_instr_o,
    output logic [CW-1:0]   alloc_cnt_o,
    output logic [CW-1:0]   unfilled_cnt_o
);

    logic [XLEN-1:0] pc_q     [DEPTH];
    logic [XLEN-1:0] instr_q  [DEPTH];
    logic [DEPTH-1:0] filled_q;

    logic [PW-1:0] rd_ptr_q, wr_ptr_q, fill_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] unf_q, unf_d;

    always_comb begin
        cnt_d = cnt_q + CW'(alloc_i) - CW'(pop_i);
        unf_d = unf_q + CW'(alloc_i) - CW'(fill_i);
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            cnt_q      <= '0;
            unf_q      <= '0;
            filled_q   <= '0;
        end else begin
            // alloc targets a free slot and fill an allocated one, so the indices never collide
            if (alloc_i) begin
                filled_q[wr_ptr_q] <= 1'b0;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (fill_i) begin
                filled_q[fill_ptr_q] <= 1'b1;
                fill_ptr_q           <= fill_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_i) begin
            pc_q[wr_ptr_q] <= alloc_pc_i;
        end
        if (fill_i) begin
            instr_q[fill_ptr_q] <= fill_data_i;
        end
    end

    assign head_valid_o   = (cnt_q != '0);
    assign head_filled_o  = (cnt_q != '0) && filled_q[rd_ptr_q];
    assign head_pc_o      = pc_q[rd_ptr_q];
    assign head_instr_o   = instr_q[rd_ptr_q];
    assign alloc_cnt_o    = cnt_q;
    assign unfilled_cnt_o = unf_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory handshake, redirect drop accounting and the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds PerfFetchCnt / PerfBubbleCnt counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [31:0] ImemAddr,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    input  logic        StallDe,
    input  logic        PCSrcEx,
    input  logic [31:0] PCTargetEx,
    output logic [31:0] InstrDe,
    output logic [31:0] PCDe,
    output logic [31:0] PCplus4De,
    output logic        ValidDe
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] PerfFetchCnt,
    output logic [31:0] PerfBubbleCnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] drop_q, drop_d;
    ifid_t         ifid_q, ifid_d;

    logic          head_valid, head_filled;
    logic [31:0]   head_pc, head_instr;
    logic [CW-1:0] alloc_cnt, unfilled_cnt;

    logic [CW:0]   occ;
    logic          req_valid, req_fire, rsp_drop, fill_en, advance, bypass, pop;

    fetch_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (PCSrcEx),
        .alloc_i        (req_fire),
        .alloc_pc_i     (pc_q),
        .fill_i         (fill_en),
        .fill_data_i    (ImemRspData),
        .pop_i          (pop),
        .head_valid_o   (head_valid),
        .head_filled_o  (head_filled),
        .head_pc_o      (head_pc),
        .head_instr_o   (head_instr),
        .alloc_cnt_o    (alloc_cnt),
        .unfilled_cnt_o (unfilled_cnt)
    );

    always_comb begin
        occ       = {1'b0, alloc_cnt} + {1'b0, drop_q};
        req_valid = !rst && !PCSrcEx && (occ < DEPTH_W);
        req_fire  = req_valid && ImemReqReady;
        rsp_drop  = ImemRspValid && (drop_q != '0);
        fill_en   = ImemRspValid && (drop_q == '0) && !PCSrcEx;
        advance   = !StallDe && !PCSrcEx;
        // the oldest unfilled entry is the head whenever the head is unfilled
        bypass    = head_valid && !head_filled && fill_en;
        pop       = advance && (head_filled || bypass);

        pc_d   = pc_q;
        drop_d = drop_q;
        ifid_d = ifid_q;

        if (PCSrcEx) begin
            pc_d         = PCTargetEx;
            drop_d       = drop_q + unfilled_cnt - CW'(ImemRspValid);
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
        end else begin
            if (req_fire) begin
                pc_d = pc_plus4(pc_q);
            end
            if (rsp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (advance) begin
                ifid_d.pc    = head_pc;
                ifid_d.pc4   = pc_plus4(head_pc);
                ifid_d.valid = 1'b1;
                if (head_filled) begin
                    ifid_d.instr = head_instr;
                end else if (bypass) begin
                    ifid_d.instr = ImemRspData;
                end else begin
                    ifid_d.instr = NOP_INSTR;
                    ifid_d.pc    = ifid_q.pc;
                    ifid_d.pc4   = ifid_q.pc4;
                    ifid_d.valid = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            drop_q       <= '0;
            ifid_q.instr <= NOP_INSTR;
            ifid_q.pc    <= '0;
            ifid_q.pc4   <= '0;
            ifid_q.valid <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
            ifid_q <= ifid_d;
        end
    end

    // A response must belong either to a live buffer entry or to a request being dropped.
    rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
        ImemRspValid |-> ((unfilled_cnt != '0) || (drop_q != '0)));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (pop) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (advance && !pop) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign PerfFetchCnt  = perf_fetch_q;
    assign PerfBubbleCnt = perf_bubble_q;
`endif

    assign ImemReqValid = req_valid;
    assign ImemAddr     = pc_q;
    assign InstrDe      = ifid_q.instr;
    assign PCDe         = ifid_q.pc;
    assign PCplus4De    = ifid_q.pc4;
    assign ValidDe      = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with selectable latency, directed cycle table,
// and a scoreboard of the PCs the decode stage should consume.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        ImemReqValid;
    logic        ImemReqReady;
    logic [31:0] ImemAddr;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic        StallDe;
    logic        PCSrcEx;
    logic [31:0] PCTargetEx;
    logic [31:0] InstrDe;
    logic [31:0] PCDe;
    logic [31:0] PCplus4De;
    logic        ValidDe;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_bubble;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] pend_addr_q[$];
    int          pend_due_q[$];
    int          mcyc     = 0;
    int          last_due = 0;
    int          mem_lat  = 1;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ImemReqValid (ImemReqValid),
        .ImemReqReady (ImemReqReady),
        .ImemAddr     (ImemAddr),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .StallDe      (StallDe),
        .PCSrcEx      (PCSrcEx),
        .PCTargetEx   (PCTargetEx),
        .InstrDe      (InstrDe),
        .PCDe         (PCDe),
        .PCplus4De    (PCplus4De),
        .ValidDe      (ValidDe)
`ifdef FETCH_PERF_CNT_EN
        ,
        .PerfFetchCnt  (perf_fetch),
        .PerfBubbleCnt (perf_bubble)
`endif
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // instruction memory: accept sampled mid-cycle, answer in order after mem_lat cycles
    always @(negedge clk) begin
        if (rst) begin
            pend_addr_q.delete();
            pend_due_q.delete();
            last_due = mcyc;
        end else if (ImemReqValid && ImemReqReady) begin
            int due;
            due = mcyc + mem_lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr_q.push_back(ImemAddr);
            pend_due_q.push_back(due);
        end
    end

    always @(posedge clk) begin
        mcyc++;
        #1;
        if (pend_due_q.size() != 0 && pend_due_q[0] == mcyc) begin
            ImemRspValid = 1'b1;
            ImemRspData  = mem_word(pend_addr_q.pop_front());
            void'(pend_due_q.pop_front());
        end else begin
            ImemRspValid = 1'b0;
            ImemRspData  = 32'h0;
        end
    end

    // scoreboard monitor: decode consumes IF/ID on any non-stalled, non-flushed cycle
    always @(negedge clk) begin
        if (!rst && ValidDe && !StallDe && !PCSrcEx) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_delivery: got pc %h expected none", PCDe);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("de_pc", PCDe, e);
                check("de_pc4", PCplus4De, e + 32'd4);
                check("de_instr", InstrDe, mem_word(e));
            end
        end
    end

    // stimulus
    initial begin
        rst          = 1'b1;
        ImemReqReady = 1'b1;
        ImemRspValid = 1'b0;
        ImemRspData  = 32'h0;
        StallDe      = 1'b0;
        PCSrcEx      = 1'b0;
        PCTargetEx   = 32'h0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", ValidDe, 0);
        check("rst_instr", InstrDe, NOP);
        check("rst_pc", PCDe, 0);
        check("rst_pc4", PCplus4De, 0);
        check("rst_req_valid", ImemReqValid, 0);
        check("rst_addr", ImemAddr, 0);
        @(posedge clk);
        #1;

        for (int c = 0; c < 52; c++) begin
            rst          = (c == 33);
            StallDe      = (c >= 4 && c <= 6) || (c == 27);
            PCSrcEx      = (c == 22) || (c == 27);
            PCTargetEx   = 32'h100;
            ImemReqReady = !((c >= 10 && c <= 14) || c >= 45);
            mem_lat      = (c >= 17 && c <= 33) ? 2 : 1;
            if (c == 0 || c == 34) begin
                for (int k = 0; k < 11; k++) exp_q.push_back(32'(4 * k));
            end
            if (c == 22) exp_q.push_back(32'h100);
            if (c == 27) begin
                exp_q.push_back(32'h100);
                exp_q.push_back(32'h104);
            end

            @(negedge clk);
            if (c == 0) begin
                check("c0_req_valid", ImemReqValid, 1);
                check("c0_addr", ImemAddr, 32'h0);
            end
            if (c == 1) begin
                check("c1_valid", ValidDe, 0);
                check("c1_addr", ImemAddr, 32'h4);
            end
            if (c == 2) begin
                check("c2_valid", ValidDe, 1);
                check("c2_addr", ImemAddr, 32'h8);
            end
            if (c == 5) check("stall_full_req", ImemReqValid, 0);
            if (c == 6) begin
                check("stall_full_req2", ImemReqValid, 0);
                check("stall_hold_pc", PCDe, 32'h8);
                check("stall_hold_valid", ValidDe, 1);
            end
            if (c == 8) begin
                check("resume_req", ImemReqValid, 1);
                check("resume_addr", ImemAddr, 32'h14);
            end
            if (c == 12) begin
                check("noready_valid", ValidDe, 0);
                check("noready_instr", InstrDe, NOP);
                check("noready_addr", ImemAddr, 32'h1c);
                check("noready_pc_hold", PCDe, 32'h18);
            end
            if (c == 14) check("noready_addr2", ImemAddr, 32'h1c);
            if (c == 22) check("redir_no_req", ImemReqValid, 0);
            if (c == 23) begin
                check("redir_valid", ValidDe, 0);
                check("redir_addr", ImemAddr, 32'h100);
                check("redir_req", ImemReqValid, 1);
            end
            if (c == 27) check("redir_stall_no_req", ImemReqValid, 0);
            if (c == 28) begin
                check("redir_stall_valid", ValidDe, 0);
                check("redir_stall_addr", ImemAddr, 32'h100);
            end
            if (c == 33) check("midrst_req", ImemReqValid, 0);
            if (c == 34) begin
                check("midrst_valid", ValidDe, 0);
                check("midrst_instr", InstrDe, NOP);
                check("midrst_pc", PCDe, 0);
                check("midrst_pc4", PCplus4De, 0);
                check("midrst_addr", ImemAddr, 0);
                check("midrst_req", ImemReqValid, 1);
            end
            if (c == 47) begin
                check("drain_valid", ValidDe, 0);
                check("drain_addr", ImemAddr, 32'h2c);
            end
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch", perf_fetch, 32'd11);
        check("perf_bubble", perf_bubble, 32'd7);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
